// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response channel plus the decode-side
// instruction handshake. master = fetch unit, slave = memory/decode environment.
interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   modport master (
      output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch front end: owns the fetch PC, issues in-order imem requests,
// buffers responses for decode and squashes wrong-path work on redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rstB,
   input  logic         redirect_valid,
   input  logic [31:0]  redirect_pc,
   fetch_unit_if.master bus
);
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned CWP = CW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] count_q, count_d;
   logic          req_valid_q, req_valid_d;
   logic          instr_valid_q, instr_valid_d;
   entry_t        fifo_q [FIFO_DEPTH];
   entry_t        fifo_d [FIFO_DEPTH];

   logic req_xfer, rsp_fire, push, pop;

   always_comb begin
      req_xfer      = req_valid_q && bus.imem_req_ready;
      rsp_fire      = bus.imem_rsp_valid && (state_q != BOOT);
      pop           = instr_valid_q && bus.instr_ready;
      push          = 1'b0;
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      count_d       = count_q;
      fifo_d        = fifo_q;

      if (req_xfer) begin
         fetch_pc_d    = fetch_pc_q + 32'd4;
         outstanding_d = outstanding_d + CW'(1);
      end
      if (rsp_fire)
         outstanding_d = outstanding_d - CW'(1);

      case (state_q)
         BOOT:  state_d = RUN;
         RUN:   push = rsp_fire;
         DRAIN: begin
            if (rsp_fire)
               drop_cnt_d = drop_cnt_q - CW'(1);
            if (drop_cnt_q == '0)
               state_d = RUN;
         end
         default: state_d = BOOT;
      endcase

      // Head is entry 0 and doubles as the output register; it only shifts when a
      // successor exists, so instr/instr_pc hold their last values once empty.
      if (pop) begin
         if (count_q > CW'(1))
            for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++)
               fifo_d[i] = fifo_q[i + 1];
         count_d = count_q - CW'(1);
      end
      if (push) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++)
            if (CW'(i) == count_d) begin
               fifo_d[i].instr = bus.imem_rsp_data;
               fifo_d[i].pc    = rsp_pc_q;
            end
         count_d  = count_d + CW'(1);
         rsp_pc_d = rsp_pc_q + 32'd4;
      end

      // Redirect wins over everything above; outstanding_d already counts a request
      // accepted this cycle and excludes a response arriving this cycle.
      if (redirect_valid && (state_q != BOOT)) begin
         fetch_pc_d = redirect_pc & ~32'd3;
         rsp_pc_d   = redirect_pc & ~32'd3;
         count_d    = '0;
         fifo_d     = fifo_q;
         drop_cnt_d = outstanding_d;
         state_d    = ((state_q == DRAIN) || (outstanding_d != '0)) ? DRAIN : RUN;
      end

      req_valid_d   = (state_d == RUN) &&
                      (({1'b0, outstanding_d} + {1'b0, count_d}) < CWP'(FIFO_DEPTH));
      instr_valid_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (!rstB) begin
         state_q       <= BOOT;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         count_q       <= '0;
         req_valid_q   <= 1'b0;
         instr_valid_q <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++)
            if (i == 0) fifo_q[i] <= {NOP, RESET_PC};
            else        fifo_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         count_q       <= count_d;
         req_valid_q   <= req_valid_d;
         instr_valid_q <= instr_valid_d;
         fifo_q        <= fifo_d;
      end
   end

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.instr_valid    = instr_valid_q;
   assign bus.instr          = fifo_q[0].instr;
   assign bus.instr_pc       = fifo_q[0].pc;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rstB)
      !(push && !pop && (count_q == CW'(FIFO_DEPTH))));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with optional response hold,
// hand-traced expected values checked on the falling edge.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rstB = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        hold_rsp = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          xfer_cnt = 0;
   logic [31:0] mem_q[$];

   fetch_unit_if bus_if ();

   fetch_unit dut (
      .clk            (clk),
      .rstB           (rstB),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus_if)
   );

   always #5 clk = ~clk;

   // Memory: a request seen before edge K answers in the cycle after edge K.
   always @(negedge clk) begin
      #1;
      if (!rstB) begin
         mem_q.delete();
         xfer_cnt = 0;
         bus_if.imem_rsp_valid = 1'b0;
         bus_if.imem_rsp_data  = '0;
      end else begin
         if (!hold_rsp && mem_q.size() > 0) begin
            bus_if.imem_rsp_valid = 1'b1;
            bus_if.imem_rsp_data  = 32'h1300_0000 | mem_q.pop_front();
         end else begin
            bus_if.imem_rsp_valid = 1'b0;
         end
         if (bus_if.imem_req_valid && bus_if.imem_req_ready) begin
            mem_q.push_back(bus_if.imem_req_addr);
            xfer_cnt++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstB = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      hold_rsp = 1'b0;
      bus_if.imem_req_ready = 1'b0;
      bus_if.instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      rstB = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_valid"}, 32'(bus_if.imem_req_valid), 32'd0);
      chk({tag, "_req_addr"}, bus_if.imem_req_addr, 32'h0);
      chk({tag, "_instr_valid"}, 32'(bus_if.instr_valid), 32'd0);
      chk({tag, "_instr"}, bus_if.instr, 32'h0000_0013);
      chk({tag, "_instr_pc"}, bus_if.instr_pc, 32'h0);
   endtask

   task automatic wait_req(input string tag, input logic [31:0] exp_addr);
      int unsigned n = 0;
      int unsigned stale = 0;
      while (bus_if.imem_req_valid !== 1'b1 && n < 30) begin
         if (bus_if.instr_valid === 1'b1) stale++;
         @(negedge clk);
         n++;
      end
      chk({tag, "_req_seen"}, 32'(bus_if.imem_req_valid), 32'd1);
      chk({tag, "_req_addr"}, bus_if.imem_req_addr, exp_addr);
      chk({tag, "_no_stale"}, 32'(stale), 32'd0);
   endtask

   task automatic wait_instr(input string tag, input logic [31:0] exp_pc);
      int unsigned n = 0;
      while (bus_if.instr_valid !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, 32'(bus_if.instr_valid), 32'd1);
      chk({tag, "_pc"}, bus_if.instr_pc, exp_pc);
      chk({tag, "_data"}, bus_if.instr, 32'h1300_0000 | exp_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.imem_req_ready = 1'b0;
      bus_if.instr_ready = 1'b0;
      bus_if.imem_rsp_valid = 1'b0;
      bus_if.imem_rsp_data = '0;

      // 1: reset values, boot latency, first fetch stream
      do_reset();
      chk_reset_vals("t1_reset");
      bus_if.imem_req_ready = 1'b1;
      bus_if.instr_ready = 1'b1;
      @(negedge clk);
      chk("t1_n1_req_valid", 32'(bus_if.imem_req_valid), 32'd1);
      chk("t1_n1_addr", bus_if.imem_req_addr, 32'h0);
      chk("t1_n1_ivalid", 32'(bus_if.instr_valid), 32'd0);
      @(negedge clk);
      chk("t1_n2_addr", bus_if.imem_req_addr, 32'h4);
      chk("t1_n2_ivalid", 32'(bus_if.instr_valid), 32'd0);
      @(negedge clk);
      chk("t1_n3_ivalid", 32'(bus_if.instr_valid), 32'd1);
      chk("t1_n3_pc", bus_if.instr_pc, 32'h0);
      chk("t1_n3_instr", bus_if.instr, 32'h1300_0000);
      chk("t1_n3_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
      @(negedge clk);
      chk("t1_n4_pc", bus_if.instr_pc, 32'h4);
      chk("t1_n4_req_valid", 32'(bus_if.imem_req_valid), 32'd1);
      chk("t1_n4_addr", bus_if.imem_req_addr, 32'h8);

      // 2: decode stalled -> credit limit of two, then in-order delivery
      do_reset();
      bus_if.imem_req_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("t2_n4_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
      repeat (2) @(negedge clk);
      chk("t2_n6_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
      chk("t2_xfer_cnt", 32'(xfer_cnt), 32'd2);
      wait_instr("t2_i0", 32'h0);
      bus_if.instr_ready = 1'b1;
      @(negedge clk);
      wait_instr("t2_i1", 32'h4);
      @(negedge clk);
      wait_instr("t2_i2", 32'h8);

      // 4: unaligned redirect with nothing outstanding, then PC wrap
      do_reset();
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0102;
      @(negedge clk);
      chk("t4_req_valid", 32'(bus_if.imem_req_valid), 32'd1);
      chk("t4_addr", bus_if.imem_req_addr, 32'h100);
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      bus_if.imem_req_ready = 1'b1;
      chk("t4_wrap_addr0", bus_if.imem_req_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("t4_wrap_valid", 32'(bus_if.imem_req_valid), 32'd1);
      chk("t4_wrap_addr1", bus_if.imem_req_addr, 32'h0);

      // 3: two in flight at 0x10/0x14, redirect to 0x100 drops both
      do_reset();
      hold_rsp = 1'b1;
      bus_if.instr_ready = 1'b1;
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h10;
      @(negedge clk);
      redirect_valid = 1'b0;
      bus_if.imem_req_ready = 1'b1;
      chk("t3_addr10", bus_if.imem_req_addr, 32'h10);
      @(negedge clk);
      chk("t3_addr14", bus_if.imem_req_addr, 32'h14);
      @(negedge clk);
      chk("t3_full_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clk);
      redirect_valid = 1'b0;
      hold_rsp = 1'b0;
      chk("t3_drain_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
      wait_req("t3", 32'h100);
      wait_instr("t3_first", 32'h100);

      // 5: redirect coincides with a request transfer and a response
      do_reset();
      bus_if.imem_req_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t5_pre_addr", bus_if.imem_req_addr, 32'h4);
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      @(negedge clk);
      redirect_valid = 1'b0;
      bus_if.instr_ready = 1'b1;
      chk("t5_n3_ivalid", 32'(bus_if.instr_valid), 32'd0);
      chk("t5_n3_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
      @(negedge clk);
      chk("t5_n4_ivalid", 32'(bus_if.instr_valid), 32'd0);
      wait_req("t5", 32'h200);
      wait_instr("t5_first", 32'h200);

      // 6: reset while draining two wrong-path requests
      do_reset();
      bus_if.imem_req_ready = 1'b1;
      repeat (4) @(negedge clk);
      bus_if.instr_ready = 1'b1;
      hold_rsp = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_empty_ivalid", 32'(bus_if.instr_valid), 32'd0);
      chk("t6_hold_instr", bus_if.instr, 32'h1300_0004);
      chk("t6_hold_pc", bus_if.instr_pc, 32'h4);
      chk("t6_full_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h300;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("t6_drain_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
      chk("t6_drain_pc", bus_if.instr_pc, 32'h4);
      rstB = 1'b0;
      @(negedge clk);
      chk_reset_vals("t6_reset");
      rstB = 1'b1;
      hold_rsp = 1'b0;
      @(negedge clk);
      chk("t6_boot_req_valid", 32'(bus_if.imem_req_valid), 32'd1);
      chk("t6_boot_addr", bus_if.imem_req_addr, 32'h0);
      wait_instr("t6_first", 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
